alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the 8-bit combinational ALU. It keeps the same eight
//  operations (3-bit sel), now at WIDTH bits, and registers result, remainder and flags.
//  Rotate, duplicate and divide run iteratively, one bit per cycle.
//  Sits between operand issue logic (valid/ready in) and the writeback stage (valid/ready out).
// PARAMETERS
//  WIDTH  8  operand/result width in bits, >=4; flags stay 8 bits for any WIDTH
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands/sel valid
//  in_ready   out  1      block can accept (IDLE only)
//  sel        in   3      000 add2c, 001 sub2c, 010 addmag, 011 submag, 100 rotl, 101 rotr, 110 dup, 111 div
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (count for 100/101/110, divisor for 111)
//  out_valid  out  1      result/rem/flags valid; held until out_ready
//  out_ready  in   1      consumer accepts
//  result     out  WIDTH  result
//  rem        out  WIDTH  remainder (div only, else 0)
//  flags      out  8      [0]Z [1]N [2]C [3]V [4]P [5]DZ [6]R [7]0
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE, in_ready=1, out_valid=0, result/rem/flags=0.
//   Reset is valid at any time and aborts any op in flight with no output.
//  Accept: in_valid&in_ready at edge k latches a,b,sel; state goes to EXEC.
//  FSM states:
//   IDLE -> EXEC on accept.
//   EXEC -> DONE when the iteration counter is exhausted.
//   DONE -> IDLE on out_ready.
//   in_ready=0 outside IDLE, so there is no overlap.
//  EXEC cycles:
//   000-011 and div-by-zero: 1 cycle.
//   100/101: max(b mod WIDTH, 1).
//   110: max(min(b, WIDTH), 1).
//   111 (b!=0): WIDTH cycles, restoring division, one quotient bit per cycle.
//  Latency: out_valid rises 1+EXEC cycles after the accept edge (add=2, div WIDTH+1).
//  DONE: out_valid=1; result/rem/flags are stable until the handshake edge.
//   out_ready already high at DONE entry -> exactly one valid cycle.
//  Arithmetic (WIDTH bits, wrap):
//   000: a+b. C=carry out. V=signed overflow.
//   001: a-b. C=borrow (a<b unsigned). V=signed overflow.
//   010: a+b unsigned. C=carry. V=0.
//   011: |a-b|. C=(a<b). V=0.
//   100/101: rotate by b mod WIDTH. C=last bit rotated out; 0 when count=0.
//   110: a<<b; b>=WIDTH gives 0. C=1 if any 1 was shifted out.
//   111: result=a/b, rem=a%b unsigned. R=(rem!=0).
//   111, b=0: result=all ones, rem=a, DZ=1, C=V=R=0.
//  Z=(result==0). N=result[WIDTH-1]. P=even parity of result (1 if even count of ones).
//  Flags not listed for an op are 0. rem=0 for every op except 111.
// TESTING (WIDTH=8)
//  add2c a=56 b=79 -> result CF, flags 1A, out_valid 2 cycles after accept
//  sub2c a=A3 b=A4 -> result FF, flags 16; submag a=0F b=FF -> F0, flags 16
//  rotl a=0F b=04 -> F0, flags 12, latency 5; dup a=01 b=FF -> 00, flags 15, latency 9
//  div a=FF b=02 -> result 7F rem 01 flags 40 latency 9; b=00 -> FF rem FF flags 32 latency 2
//  out_ready low 3 cycles in DONE -> outputs stable, in_ready=0; rst mid-div -> next cycle IDLE, out_valid=0, in_ready=1

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: eight operations at WIDTH bits with registered result, remainder and flags.
// Rotate, shift-duplicate and divide iterate one bit per cycle; arithmetic completes in a single step.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem,
    output logic [7:0]       flags
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             noop_q, noop_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [7:0]       flags_q, flags_d;

    logic [WIDTH-1:0]        rot_n, dup_n;
    logic [CW-1:0]           exec_n;
    logic                    exec_noop;
    logic [WIDTH:0]          sum_w, dif_w, div_t, div_sub;
    logic signed [WIDTH-1:0] a_s, b_s, sum_s, dif_s;

    function automatic logic [7:0] mk_flags(input logic [WIDTH-1:0] res, input logic c,
                                            input logic v, input logic dz, input logic r);
        mk_flags = {1'b0, r, dz, ~^res, v, c, res[WIDTH-1], (res == '0)};
    endfunction

    assign rot_n = b % WIDTH_V;
    assign dup_n = (b >= WIDTH_V) ? WIDTH_V : b;

    // Iteration count loaded at accept; a zero rotate/shift still spends one no-op step
    always_comb begin
        exec_n    = CW'(1);
        exec_noop = 1'b0;
        case (sel)
            3'b100, 3'b101: begin
                exec_noop = (rot_n == '0);
                exec_n    = exec_noop ? CW'(1) : CW'(rot_n);
            end
            3'b110: begin
                exec_noop = (dup_n == '0);
                exec_n    = exec_noop ? CW'(1) : CW'(dup_n);
            end
            3'b111:  exec_n = (b == '0) ? CW'(1) : WIDTH_C;
            default: exec_n = CW'(1);
        endcase
    end

    assign sum_w   = {1'b0, work_q} + {1'b0, b_q};
    assign dif_w   = {1'b0, work_q} - {1'b0, b_q};
    assign a_s     = work_q;
    assign b_s     = b_q;
    assign sum_s   = sum_w[WIDTH-1:0];
    assign dif_s   = dif_w[WIDTH-1:0];
    assign div_t   = {part_q, work_q[WIDTH-1]};
    assign div_sub = div_t - {1'b0, b_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        b_d      = b_q;
        noop_d   = noop_q;
        work_d   = work_q;
        part_d   = part_q;
        c_d      = c_q;
        v_d      = v_q;
        dz_d     = dz_q;
        result_d = result_q;
        rem_d    = rem_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_EXEC;
                    cnt_d   = exec_n;
                    noop_d  = exec_noop;
                    sel_d   = sel;
                    b_d     = b;
                    work_d  = a;
                    part_d  = '0;
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    dz_d    = 1'b0;
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                    if (!noop_q) begin
                        case (sel_q)
                            3'b000: begin
                                work_d = sum_w[WIDTH-1:0];
                                c_d    = sum_w[WIDTH];
                                v_d    = ((a_s < 0) == (b_s < 0)) && ((sum_s < 0) != (a_s < 0));
                            end
                            3'b001: begin
                                work_d = dif_w[WIDTH-1:0];
                                c_d    = dif_w[WIDTH];
                                v_d    = ((a_s < 0) != (b_s < 0)) && ((dif_s < 0) != (a_s < 0));
                            end
                            3'b010: begin
                                work_d = sum_w[WIDTH-1:0];
                                c_d    = sum_w[WIDTH];
                            end
                            3'b011: begin
                                work_d = dif_w[WIDTH] ? (b_q - work_q) : dif_w[WIDTH-1:0];
                                c_d    = dif_w[WIDTH];
                            end
                            3'b100: begin
                                work_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                                c_d    = work_q[WIDTH-1];
                            end
                            3'b101: begin
                                work_d = {work_q[0], work_q[WIDTH-1:1]};
                                c_d    = work_q[0];
                            end
                            3'b110: begin
                                work_d = {work_q[WIDTH-2:0], 1'b0};
                                c_d    = c_q | work_q[WIDTH-1];
                            end
                            default: begin
                                // Restoring division: quotient shifts in through work_q, partial remainder in part_q
                                if (b_q == '0) begin
                                    work_d = '1;
                                    part_d = work_q;
                                    dz_d   = 1'b1;
                                end else if (div_t >= {1'b0, b_q}) begin
                                    part_d = div_sub[WIDTH-1:0];
                                    work_d = {work_q[WIDTH-2:0], 1'b1};
                                end else begin
                                    part_d = div_t[WIDTH-1:0];
                                    work_d = {work_q[WIDTH-2:0], 1'b0};
                                end
                            end
                        endcase
                    end
                end else begin
                    state_d  = S_DONE;
                    result_d = work_q;
                    rem_d    = (sel_q == 3'b111) ? part_q : '0;
                    flags_d  = mk_flags(work_q, c_q, v_q, dz_q,
                                        (sel_q == 3'b111) && !dz_q && (part_q != '0));
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            rem_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            flags_q  <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        sel_q  <= sel_d;
        b_q    <= b_d;
        noop_q <= noop_d;
        work_q <= work_d;
        part_q <= part_d;
        c_q    <= c_d;
        v_q    <= v_d;
        dz_q   <= dz_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign rem       = rem_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8: directed vector table, handshake/reset corner cases, random ops vs model.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] sel;
    logic [7:0] a, b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result, rem, flags;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .rem(rem), .flags(flags)
    );

    typedef struct {
        logic [2:0] s;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [7:0] rm;
        logic [7:0] fl;
        int         lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions
    function automatic void model(input logic [2:0] s, input logic [7:0] av, input logic [7:0] bv,
                                  output logic [7:0] r, output logic [7:0] rm,
                                  output logic [7:0] fl, output int lat);
        int ua, ub, sa, sb, sr, res, n;
        bit c, v, dz, rr;
        ua = av; ub = bv; sa = $signed(av); sb = $signed(bv);
        c = 0; v = 0; dz = 0; rr = 0; res = 0; lat = 2; rm = 0;
        case (s)
            3'd0: begin res = ua + ub; c = (res > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            3'd1: begin res = ua - ub; c = (ua < ub);  sr = sa - sb; v = (sr > 127) || (sr < -128); end
            3'd2: begin res = ua + ub; c = (res > 255); end
            3'd3: begin res = (ua >= ub) ? ua - ub : ub - ua; c = (ua < ub); end
            3'd4: begin
                n = ub % 8;
                res = ((ua << n) | (ua >> (8 - n))) & 255;
                c = (n != 0) && ((res & 1) != 0);
                lat = 1 + ((n == 0) ? 1 : n);
            end
            3'd5: begin
                n = ub % 8;
                res = ((ua >> n) | (ua << (8 - n))) & 255;
                c = (n != 0) && (((res >> 7) & 1) != 0);
                lat = 1 + ((n == 0) ? 1 : n);
            end
            3'd6: begin
                n = (ub > 8) ? 8 : ub;
                res = (ua << n) & 255;
                c = (n != 0) && ((ua >> (8 - n)) != 0);
                lat = 1 + ((n == 0) ? 1 : n);
            end
            default: begin
                if (ub == 0) begin
                    res = 255; rm = av; dz = 1; lat = 2;
                end else begin
                    res = ua / ub; n = ua % ub; rm = n[7:0]; rr = (n != 0); lat = 9;
                end
            end
        endcase
        r = res[7:0];
        fl = {1'b0, rr, dz, ($countones(r) % 2 == 0), v, c, r[7], (r == 8'd0)};
    endfunction

    // Issue one op (called just after a rising edge) and wait for out_valid; leaves the handshake pending
    task automatic run_op(input logic [2:0] s, input logic [7:0] av, input logic [7:0] bv,
                          output logic [7:0] r, output logic [7:0] rm, output logic [7:0] fl,
                          output int lat);
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        sel = s; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            tests++;
            fails++;
            $display("FAIL out_valid_timeout sel=%0d actual=never expected=within 40 cycles", s);
        end
        r = result; rm = rem; fl = flags;
    endtask

    vec_t vecs[12];

    initial begin
        logic [7:0] r, rm, fl, er, erm, efl, r0, rm0, fl0;
        int lat, elat;

        vecs[0]  = '{3'd0, 8'h56, 8'h79, 8'hCF, 8'h00, 8'h1A, 2};
        vecs[1]  = '{3'd1, 8'hA3, 8'hA4, 8'hFF, 8'h00, 8'h16, 2};
        vecs[2]  = '{3'd3, 8'h0F, 8'hFF, 8'hF0, 8'h00, 8'h16, 2};
        vecs[3]  = '{3'd4, 8'h0F, 8'h04, 8'hF0, 8'h00, 8'h12, 5};
        vecs[4]  = '{3'd6, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h15, 9};
        vecs[5]  = '{3'd7, 8'hFF, 8'h02, 8'h7F, 8'h01, 8'h40, 9};
        vecs[6]  = '{3'd7, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h32, 2};
        vecs[7]  = '{3'd2, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h15, 2};
        vecs[8]  = '{3'd5, 8'h01, 8'h09, 8'h80, 8'h00, 8'h06, 2};
        vecs[9]  = '{3'd4, 8'hA5, 8'h08, 8'hA5, 8'h00, 8'h12, 2};
        vecs[10] = '{3'd6, 8'h81, 8'h00, 8'h81, 8'h00, 8'h12, 2};
        vecs[11] = '{3'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 8'h08, 2};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = 3'd0; a = 8'd0; b = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", {24'd0, result}, 32'd0);
        check("reset_rem", {24'd0, rem}, 32'd0);
        check("reset_flags", {24'd0, flags}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, r, rm, fl, lat);
            check($sformatf("vec%0d_result", i), {24'd0, r}, {24'd0, vecs[i].r});
            check($sformatf("vec%0d_rem", i), {24'd0, rm}, {24'd0, vecs[i].rm});
            check($sformatf("vec%0d_flags", i), {24'd0, fl}, {24'd0, vecs[i].fl});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_single_valid", i), {31'd0, out_valid}, 32'd0);
        end

        // Back-pressure: outputs hold while out_ready is low
        out_ready = 1'b0;
        run_op(3'd7, 8'hFF, 8'h02, r0, rm0, fl0, lat);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_result", {24'd0, result}, {24'd0, r0});
            check("hold_rem", {24'd0, rem}, {24'd0, rm0});
            check("hold_flags", {24'd0, flags}, {24'd0, fl0});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a divide aborts it
        sel = 3'd7; a = 8'hC8; b = 8'h07; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("middiv_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_result", {24'd0, result}, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_late_valid", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 200; i++) begin
            logic [2:0] s;
            logic [7:0] av, bv;
            s  = 3'($urandom_range(0, 7));
            av = 8'($urandom);
            bv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            model(s, av, bv, er, erm, efl, elat);
            run_op(s, av, bv, r, rm, fl, lat);
            check($sformatf("rand%0d_sel%0d_result", i, s), {24'd0, r}, {24'd0, er});
            check($sformatf("rand%0d_sel%0d_rem", i, s), {24'd0, rm}, {24'd0, erm});
            check($sformatf("rand%0d_sel%0d_flags", i, s), {24'd0, fl}, {24'd0, efl});
            check($sformatf("rand%0d_sel%0d_latency", i, s), lat, elat);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
